// File: rtl/mac_pkg.sv
// Shared definitions for the SRAM-fed int8 dot-product accumulator:
// FSM state encoding and lane/word geometry.
package mac_pkg;

    localparam int LANE_W     = 8;
    localparam int LANES      = 4;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mac_dot4.sv
// Combinational four-lane signed int8 dot product of two 32-bit words.
// Each lane product is sign-extended to 32 bits before summing.
module mac_dot4
    import mac_pkg::*;
(
    input  logic        [31:0] i_a,
    input  logic        [31:0] i_b,
    output logic signed [31:0] o_sum
);

    logic signed [2*LANE_W-1:0] w_prod [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [2*LANE_W-1:0] w_a_ext;
            logic signed [2*LANE_W-1:0] w_b_ext;
            // Widen both operands first so -128 * -128 cannot overflow the product.
            assign w_a_ext = {{LANE_W{i_a[gi*LANE_W+LANE_W-1]}}, i_a[gi*LANE_W +: LANE_W]};
            assign w_b_ext = {{LANE_W{i_b[gi*LANE_W+LANE_W-1]}}, i_b[gi*LANE_W +: LANE_W]};
            assign w_prod[gi] = w_a_ext * w_b_ext;
        end
    endgenerate

    // Sum the sign-extended lane products.
    always_comb begin
        o_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            o_sum = o_sum + {{(32-2*LANE_W){w_prod[i][2*LANE_W-1]}}, w_prod[i]};
        end
    end

endmodule

// File: rtl/mac_dot_unit.sv
// Dot-product engine: reads word pairs from vectors A and B through a single
// SRAM read port (A word, then B word) and accumulates the int8 dot product.
// Optional macro MAC_DOT_SAT_EN: saturate the accumulator to the signed
// 32-bit range instead of wrapping.
module mac_dot_unit
    import mac_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int LWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              acc_keep,
    input  logic [AWIDTH-1:0] base_a,
    input  logic [AWIDTH-1:0] base_b,
    input  logic [LWIDTH-1:0] len,
    output logic [AWIDTH-1:0] mac_addr,
    output logic              mac_en,
    output logic [3:0]        mac_mask,
    input  logic [31:0]       mac_rdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result
);

    state_t            r_state;
    logic [AWIDTH-1:0] r_ptr_a;
    logic [AWIDTH-1:0] r_ptr_b;
    logic [LWIDTH-1:0] r_cnt;
    logic [31:0]       r_acc;
    logic [31:0]       r_a;
    logic [31:0]       r_result;

    logic signed [31:0] w_dot;
    logic [31:0]        w_acc_next;

    mac_dot4 u_dot4 (
        .i_a   (r_a),
        .i_b   (mac_rdata),
        .o_sum (w_dot)
    );

`ifdef MAC_DOT_SAT_EN
    logic [33:0] w_sum34;
    // Add at 34 bits; bits [33:31] disagree exactly when the 32-bit result overflows.
    always_comb begin
        w_sum34 = {{2{r_acc[31]}}, r_acc} + {{2{w_dot[31]}}, w_dot};
        if (w_sum34[33:31] == 3'b000 || w_sum34[33:31] == 3'b111) begin
            w_acc_next = w_sum34[31:0];
        end else if (w_sum34[33]) begin
            w_acc_next = 32'h8000_0000;
        end else begin
            w_acc_next = 32'h7FFF_FFFF;
        end
    end
`else
    // Plain modulo-2^32 accumulation.
    always_comb begin
        w_acc_next = r_acc + w_dot;
    end
`endif

    // SRAM port and status decode straight from the registered state, so an
    // asynchronous reset drops them in the same instant.
    always_comb begin
        mac_en   = (r_state == RD_A) || (r_state == RD_B);
        mac_mask = {4{mac_en}};
        busy     = mac_en;
        done     = (r_state == DONE);
        result   = r_result;
        mac_addr = '0;
        if (r_state == RD_A) begin
            mac_addr = r_ptr_a;
        end else if (r_state == RD_B) begin
            mac_addr = r_ptr_b;
        end
    end

    // Command FSM: accept in IDLE, alternate A/B reads, publish on DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr_a  <= '0;
            r_ptr_b  <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_a      <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ptr_a <= base_a;
                        r_ptr_b <= base_b;
                        r_cnt   <= len;
                        if (!acc_keep) begin
                            r_acc <= '0;
                        end
                        if (len == '0) begin
                            r_result <= acc_keep ? r_acc : 32'd0;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= RD_A;
                        end
                    end
                end
                RD_A: begin
                    r_a     <= mac_rdata;
                    r_ptr_a <= r_ptr_a + AWIDTH'(WORD_BYTES);
                    r_state <= RD_B;
                end
                RD_B: begin
                    r_acc   <= w_acc_next;
                    r_ptr_b <= r_ptr_b + AWIDTH'(WORD_BYTES);
                    r_cnt   <= r_cnt - LWIDTH'(1);
                    if (r_cnt == LWIDTH'(1)) begin
                        r_result <= w_acc_next;
                        r_state  <= DONE;
                    end else begin
                        r_state  <= RD_A;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_unit.sv
// Directed testbench for mac_dot_unit with a behavioural SRAM read port.
module tb_mac_dot_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        acc_keep = 1'b0;
    logic [31:0] base_a = '0;
    logic [31:0] base_b = '0;
    logic [15:0] len = '0;
    logic [31:0] mac_addr;
    logic        mac_en;
    logic [3:0]  mac_mask;
    logic [31:0] mac_rdata = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_mis = 0;
    int en_cnt = 0;
    int e0;
    int edges;
    int done_cnt;
    bit big_mode = 1'b0;
    logic [31:0] mem [0:255];
    logic [31:0] exp_sat;

    mac_dot_unit #(.AWIDTH(32), .LWIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .acc_keep  (acc_keep),
        .base_a    (base_a),
        .base_b    (base_b),
        .len       (len),
        .mac_addr  (mac_addr),
        .mac_en    (mac_en),
        .mac_mask  (mac_mask),
        .mac_rdata (mac_rdata),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Big mode: every word is 0x80808080 except the last B word of the
    // 32768-word run, which makes the final total exactly 0x7FFFFF00.
    function automatic logic [31:0] rd(input logic [31:0] a);
        if (big_mode) begin
            return (a == 32'h0005_FFFC) ? 32'h8080_8082 : 32'h8080_8080;
        end
        return mem[a[9:2]];
    endfunction

    // SRAM model: data appears on the negedge of a cycle with mac_en high.
    always @(negedge clk) begin
        if (mac_en === 1'b1) begin
            en_cnt++;
            mac_rdata <= rd(mac_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a command for one edge; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] l, input logic k);
        base_a   = a;
        base_b   = b;
        len      = l;
        acc_keep = k;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    // Count edges after the accepting edge until done is seen, bounded.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_en", {31'b0, mac_en}, 32'h0);
        check("rst_mask", {28'b0, mac_mask}, 32'h0);
        check("rst_addr", mac_addr, 32'h0);
        $display("reset checked");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // len=1: 0x01020304 . 0x01010101 = 10
        mem[0]  = 32'h0102_0304;
        mem[64] = 32'h0101_0101;
        e0 = en_cnt;
        issue(32'h0, 32'h100, 16'd1, 1'b0);
        check("t1_en_a", {31'b0, mac_en}, 32'h1);
        check("t1_addr_a", mac_addr, 32'h0);
        check("t1_mask_a", {28'b0, mac_mask}, 32'hF);
        check("t1_busy_a", {31'b0, busy}, 32'h1);
        @(posedge clk);
        #1;
        check("t1_addr_b", mac_addr, 32'h100);
        check("t1_done_early", {31'b0, done}, 32'h0);
        @(posedge clk);
        #1;
        check("t1_done", {31'b0, done}, 32'h1);
        check("t1_result", result, 32'd10);
        check("t1_busy_done", {31'b0, busy}, 32'h0);
        check("t1_en_done", {31'b0, mac_en}, 32'h0);
        check("t1_en_cycles", en_cnt - e0, 32'd2);
        @(posedge clk);
        #1;
        check("t1_done_pulse", {31'b0, done}, 32'h0);
        $display("txn len=1 result=0x%08h", result);

        // len=2: (-1 . 127) per lane, 8 lanes -> -1016
        mem[0]  = 32'hFFFF_FFFF;
        mem[1]  = 32'hFFFF_FFFF;
        mem[16] = 32'h7F7F_7F7F;
        mem[17] = 32'h7F7F_7F7F;
        issue(32'h0, 32'h40, 16'd2, 1'b0);
        wait_done(20, edges);
        check("t2_latency", edges, 32'd4);
        check("t2_result", result, 32'hFFFF_FC08);
        @(posedge clk);
        #1;
        check("t2_done_pulse", {31'b0, done}, 32'h0);
        $display("txn len=2 result=0x%08h edges=%0d", result, edges);

        // len=0: done at the accepting edge, no SRAM traffic, result cleared
        e0 = en_cnt;
        issue(32'h0, 32'h40, 16'd0, 1'b0);
        check("t3_done", {31'b0, done}, 32'h1);
        check("t3_result", result, 32'h0);
        check("t3_busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        check("t3_done_pulse", {31'b0, done}, 32'h0);
        check("t3_en_cycles", en_cnt - e0, 32'd0);
        $display("txn len=0 result=0x%08h", result);

        // Preload accumulator to 0x7FFFFF00 with a 32768-word run
        big_mode = 1'b1;
        issue(32'h0001_0000, 32'h0004_0000, 16'h8000, 1'b0);
        wait_done(70000, edges);
        big_mode = 1'b0;
        check("t4_latency", edges, 32'd65536);
        check("t4_result", result, 32'h7FFF_FF00);
        $display("txn len=32768 result=0x%08h edges=%0d", result, edges);
        @(posedge clk);
        #1;

        // acc_keep: 0x7FFFFF00 + 4*127*127 crosses the signed limit
        mem[0]  = 32'h7F7F_7F7F;
        mem[16] = 32'h7F7F_7F7F;
`ifdef MAC_DOT_SAT_EN
        exp_sat = 32'h7FFF_FFFF;
`else
        exp_sat = 32'h8000_FB04;
`endif
        issue(32'h0, 32'h40, 16'd1, 1'b1);
        wait_done(10, edges);
        check("t5_latency", edges, 32'd2);
        check("t5_result", result, exp_sat);
        $display("txn acc_keep result=0x%08h", result);
        @(posedge clk);
        #1;

        // start raised during RD_B is ignored
        mem[0]  = 32'h0102_0304;
        mem[64] = 32'h0101_0101;
        issue(32'h0, 32'h100, 16'd1, 1'b0);
        @(posedge clk);
        #1;
        base_a   = 32'h40;
        base_b   = 32'h40;
        len      = 16'd5;
        acc_keep = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t6_done", {31'b0, done}, 32'h1);
        check("t6_result", result, 32'd10);
        @(posedge clk);
        #1;
        check("t6_idle_busy", {31'b0, busy}, 32'h0);
        check("t6_idle_done", {31'b0, done}, 32'h0);
        $display("txn restart-ignored result=0x%08h", result);

        // Asynchronous reset in RD_B
        issue(32'h0, 32'h100, 16'd1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t7_busy", {31'b0, busy}, 32'h0);
        check("t7_en", {31'b0, mac_en}, 32'h0);
        check("t7_mask", {28'b0, mac_mask}, 32'h0);
        check("t7_addr", mac_addr, 32'h0);
        check("t7_done", {31'b0, done}, 32'h0);
        check("t7_result", result, 32'h0);
        done_cnt = 0;
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_cnt++;
        end
        check("t7_no_done", done_cnt, 32'd0);
        $display("txn reset-abort done_pulses=%0d", done_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mac_dot_unit.md
MAC_DOT_UNIT -- requirements
Module: mac_dot_unit

Interface
REQ-001 SHALL have parameter AWIDTH, default 32: byte-address width of the SRAM MAC read port.
REQ-002 SHALL have parameter LWIDTH, default 16: width of the vector-length field (words).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  command strobe, sampled at a posedge only in IDLE.
REQ-006 SHALL have port acc_keep  input  1  when 1 at start, accumulator is not cleared.
REQ-007 SHALL have port base_a  input  AWIDTH  byte address of vector A (word aligned).
REQ-008 SHALL have port base_b  input  AWIDTH  byte address of vector B (word aligned).
REQ-009 SHALL have port len  input  LWIDTH  number of 32-bit words per vector.
REQ-010 SHALL have port mac_addr  output  AWIDTH  SRAM MAC read address.
REQ-011 SHALL have port mac_en  output  1  SRAM MAC read enable.
REQ-012 SHALL have port mac_mask  output  4  byte mask; 4'hF when mac_en=1, else 4'h0.
REQ-013 SHALL have port mac_rdata  input  32  SRAM read data, updated on the negedge within the cycle mac_en is high.
REQ-014 SHALL have port busy  output  1  high in RD_A and RD_B.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port result  output  32  signed accumulator value, held until the next accepted start.

Function
REQ-017 SHALL implement FSM IDLE -> RD_A -> RD_B -> (RD_A | DONE) -> IDLE.
REQ-018 IDLE: on start=1, latch ptr_a=base_a, ptr_b=base_b, cnt=len, clear acc unless acc_keep; go RD_A, or DONE if len==0.
REQ-019 RD_A: drive mac_en=1, mac_addr=ptr_a; at posedge, capture mac_rdata into a_reg, ptr_a += 4.
REQ-020 RD_B: drive mac_en=1, mac_addr=ptr_b; at posedge, acc += dot4(a_reg, mac_rdata), ptr_b += 4, cnt -= 1; go DONE if cnt was 1, else RD_A.
REQ-021 dot4 SHALL be the sum of four signed int8 x int8 lane products (lane i = bits [8i+7:8i]), sign-extended to 32 bits.
REQ-022 Without saturation, acc SHALL wrap modulo 2^32; pointers SHALL wrap modulo 2^AWIDTH.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; result = acc.
REQ-024 Throughput SHALL be 2 cycles per word pair; done rises 2*len posedges after the edge that sampled start (1 edge if len==0).
REQ-025 start while not in IDLE SHALL be ignored; inputs other than mac_rdata are sampled only at the accepting edge.
REQ-026 mac_en SHALL be 0 in IDLE and DONE; no SRAM access when len==0.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, acc=0, a_reg=0, result=0, busy=0, done=0, mac_en=0, mac_mask=0, mac_addr=0, including mid-operation; no done pulse for an aborted command.

Configuration
REQ-028 With macro MAC_DOT_SAT_EN defined, each accumulation SHALL be computed at 34 bits and clamped to [0x80000000, 0x7FFFFFFF]; without it, accumulation wraps (REQ-022).

Structure
REQ-029 Package mac_pkg SHALL hold the FSM state enum (IDLE, RD_A, RD_B, DONE), LANE_W=8, LANES=4, WORD_BYTES=4.
REQ-030 Lane arithmetic SHALL be the combinational sub-module mac_dot4 (two 32-bit inputs, 32-bit signed sum).

Verification
REQ-031 A@0x000=0x01020304, B@0x100=0x01010101, len=1 -> mac_addr 0x000 then 0x100, done 2 edges after start, result=10.
REQ-032 A=0xFFFFFFFF x2 at 0x0, B=0x7F7F7F7F x2 at 0x40, len=2 -> result=-1016 (0xFFFFFC08), done after 4 edges.
REQ-033 len=0 -> mac_en never asserted, done 1 edge after start, result=0 (acc_keep=0).
REQ-034 acc preloaded 0x7FFFFF00 via prior command, acc_keep=1, A=B=0x7F7F7F7F, len=1 -> 0x7FFFFFFF with MAC_DOT_SAT_EN, 0x8000FB04 without.
REQ-035 start pulsed again in RD_B -> ignored, original result unchanged; rst_n low in RD_B -> all outputs 0 at once, no done pulse.
